data_lsu: RTL and testbench

Load/store unit between the core's memory pipeline stage and `data_ram`. Accepts one byte, halfword or word access at a time over a valid/ready handshake. Performs alignment and bounds checks and sign/zero-extends loads. Sub-word stores are done as read-modify-write, because `data_ram` writes full words on `we_i` and ignores `be_i`.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 38 +++
 rtl/data_lsu.sv | 156 +++++++++++++++
 tb/tb_data_lsu.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the data load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } lsu_size_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStore,
    StRmwRd,
    StRmwWr,
    StResp
  } lsu_state_e;

  // Byte lanes touched by an access; size 3 touches nothing.
  function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << addr_lo;
      SIZE_H:  be = 4'b0011 << addr_lo;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Natural alignment check; the illegal size is never aligned.
  function automatic logic lsu_align_ok(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = ~addr_lo[0];
      SIZE_W:  ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load extraction/extension and store lane merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] old_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o,
  output logic [3:0]  be_o
);

  logic [4:0]  lane_sh;
  logic [31:0] rd_sh;
  logic [31:0] mask;

  // Shift the addressed lane down for loads, up for stores, and merge under the lane mask.
  always_comb begin
    be_o    = lsu_be(size_i, addr_lo_i);
    lane_sh = {addr_lo_i, 3'b000};
    rd_sh   = rdata_i >> lane_sh;
    load_o  = rdata_i;
    mask    = '0;
    case (size_i)
      SIZE_B:  load_o = {{24{~unsigned_i & rd_sh[7]}}, rd_sh[7:0]};
      SIZE_H:  load_o = {{16{~unsigned_i & rd_sh[15]}}, rd_sh[15:0]};
      default: load_o = rdata_i;
    endcase
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be_o[i]}};
    end
    merge_o = (old_i & ~mask) | ((wdata_i << lane_sh) & mask);
  end

endmodule

// File: rtl/data_lsu.sv
// Load/store unit: one outstanding access, sub-word stores done as read-modify-write.
module data_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BYTES  = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_err_o,
  output logic                    ram_en_o,
  output logic                    ram_we_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  lsu_state_e            state_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  err_d;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;
  logic [3:0]            be;

  // Error flag for the request currently offered on the port.
  always_comb begin
    err_d = ~lsu_align_ok(req_size_i, req_addr_i[1:0]) |
            (req_addr_i >= ADDR_WIDTH'(NUM_BYTES));
  end

  lsu_align u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .addr_lo_i  (addr_q[1:0]),
    .rdata_i    (ram_rdata_i),
    .wdata_i    (wdata_q),
    .old_i      (old_q),
    .load_o     (load_data),
    .merge_o    (merge_data),
    .be_o       (be)
  );

  // Access sequencer and request/response registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            rdata_q <= '0;
            err_q   <= err_d;
            if (err_d) begin
              state_q <= StResp;
            end else if (!req_we_i) begin
              state_q <= StLoad;
            end else if (req_size_i == SIZE_W) begin
              state_q <= StStore;
            end else begin
              state_q <= StRmwRd;
            end
          end
        end
        StLoad: begin
          rdata_q <= load_data;
          state_q <= StResp;
        end
        StStore: state_q <= StResp;
        StRmwRd: begin
          old_q   <= ram_rdata_i;
          state_q <= StRmwWr;
        end
        StRmwWr: state_q <= StResp;
        StResp: begin
          if (resp_ready_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Decode handshake and RAM strobes from state; reset masks every strobe immediately.
  always_comb begin
    req_ready_o  = rst_ni & (state_q == StIdle);
    resp_valid_o = rst_ni & (state_q == StResp);
    resp_rdata_o = rdata_q;
    resp_err_o   = err_q;
    ram_en_o     = 1'b0;
    ram_we_o     = 1'b0;
    ram_addr_o   = '0;
    ram_wdata_o  = '0;
    ram_be_o     = '0;
    case (state_q)
      StLoad, StRmwRd: begin
        ram_en_o   = 1'b1;
        ram_addr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        ram_be_o   = be;
      end
      StStore: begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        ram_wdata_o = wdata_q;
        ram_be_o    = be;
      end
      StRmwWr: begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        ram_wdata_o = merge_data;
        ram_be_o    = be;
      end
      default: ;
    endcase
    ram_en_o = ram_en_o & rst_ni;
    ram_we_o = ram_we_o & rst_ni;
  end

endmodule

// File: tb/tb_data_lsu.sv
// Self-checking bench for data_lsu: directed plan items plus random accesses vs a byte-array model.
module tb_data_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        resp_valid_o, resp_ready_i, resp_err_o;
  logic [31:0] resp_rdata_o;
  logic        ram_en_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic [3:0]  ram_be_o;

  int vectors = 0;
  int miscompares = 0;

  // Word-wide RAM seen by the DUT, and the byte-level reference image.
  logic [31:0] mem [64];
  logic        clr_mem;
  logic [7:0]  ref_mem [256];

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (ram_we_o) begin
      mem[ram_addr_o[7:2]] <= ram_wdata_o;
    end
  end

  assign ram_rdata_i = mem[ram_addr_o[7:2]];

  data_lsu #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_BYTES  (256)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .ram_en_o       (ram_en_o),
    .ram_we_o       (ram_we_o),
    .ram_addr_o     (ram_addr_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_be_o       (ram_be_o),
    .ram_rdata_i    (ram_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  function automatic logic [31:0] ref_load(input int a, input int size, input logic uns);
    logic [31:0] v;
    if (size == 0) begin
      v = 32'(ref_mem[a]);
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = 32'(ref_mem[a]) + 32'(ref_mem[a+1]) * 256;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = ref_word(a / 4);
    end
    return v;
  endfunction

  // One full transaction: offer, track latency/strobes, check response, optional backpressure.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat, lat, we_cnt, we_cyc, en_cnt, bound, nbytes;
    exp_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'b00) || (addr >= 32'd256);
    exp_rdata = (exp_err || we) ? 32'h0 : ref_load(int'(addr), int'(size), uns);
    exp_lat   = exp_err ? 1 : ((!we || size == 2'd2) ? 2 : 3);

    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    resp_ready_i   = (hold == 0);
    bound = 0;
    while (!req_ready_o && bound < 20) begin
      @(negedge clk_i);
      bound++;
    end
    check("req_accept_timeout", 32'(bound < 20), 32'd1);
    @(negedge clk_i);
    // Scramble the request bus: it must be ignored outside the accept edge.
    req_valid_i    = 1'b0;
    req_we_i       = 1'($urandom);
    req_size_i     = 2'($urandom);
    req_unsigned_i = 1'($urandom);
    req_addr_i     = $urandom;
    req_wdata_i    = $urandom;

    lat = 1; we_cnt = 0; we_cyc = 0; en_cnt = 0;
    while (!resp_valid_o && lat < 10) begin
      if (ram_en_o) en_cnt++;
      if (ram_we_o) begin
        we_cnt++;
        we_cyc = lat;
      end
      check("req_ready_busy", 32'(req_ready_o), 32'd0);
      @(negedge clk_i);
      lat++;
    end
    check("resp_latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(resp_err_o), 32'(exp_err));
    check("resp_rdata", resp_rdata_o, exp_rdata);
    check("write_count", 32'(we_cnt), 32'(we && !exp_err));
    if (exp_err) check("err_no_ram_en", 32'(en_cnt), 32'd0);
    if (we && !exp_err) check("write_cycle", 32'(we_cyc), 32'(exp_lat - 1));

    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      check("hold_valid", 32'(resp_valid_o), 32'd1);
      check("hold_rdata", resp_rdata_o, exp_rdata);
      check("hold_err", 32'(resp_err_o), 32'(exp_err));
      check("hold_ready", 32'(req_ready_o), 32'd0);
    end
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    check("post_valid", 32'(resp_valid_o), 32'd0);
    check("post_ready", 32'(req_ready_o), 32'd1);

    if (we && !exp_err) begin
      nbytes = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
      for (int i = 0; i < nbytes; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
    end
    if (addr < 32'd256) check("ram_word", mem[addr[7:2]], ref_word(int'(addr[7:2])));
  endtask

  initial begin
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    rst_ni = 1'b0; clr_mem = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; resp_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check("rst_ram_en", 32'(ram_en_o), 32'd0);
    check("rst_rdata", resp_rdata_o, 32'd0);
    check("rst_addr", ram_addr_o, 32'd0);
    rst_ni = 1'b1; clr_mem = 1'b0;
    @(negedge clk_i);
    check("idle_ready", 32'(req_ready_o), 32'd1);

    // Word store then load.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    // Byte RMW then signed/unsigned byte loads.
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AB, 0);
    check("rmw_byte_word", mem[8], 32'h11AB_3344);
    do_req(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h22, 32'h0, 0);
    // Half RMW and half loads.
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_8001, 0);
    check("rmw_half_word", mem[8], 32'h8001_3344);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0);
    // Error cases.
    do_req(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFF_FFFF, 0);
    do_req(1'b0, 2'd3, 1'b0, 32'h04, 32'h0, 0);
    do_req(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 0);
    // Response backpressure.
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);

    // Reset in the write cycle of a byte RMW.
    do_req(1'b1, 2'd2, 1'b0, 32'h24, 32'hCAFE_F00D, 0);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd0; req_unsigned_i = 1'b0;
    req_addr_i = 32'h25; req_wdata_i = 32'h0000_0055;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("rmw_wr_we", 32'(ram_we_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rst_kills_we", 32'(ram_we_o), 32'd0);
    check("rst_kills_en", 32'(ram_en_o), 32'd0);
    @(negedge clk_i);
    check("rst_out_ready", 32'(req_ready_o), 32'd0);
    check("rst_out_valid", 32'(resp_valid_o), 32'd0);
    check("rst_out_rdata", resp_rdata_o, 32'd0);
    check("rst_out_err", 32'(resp_err_o), 32'd0);
    check("rst_out_addr", ram_addr_o, 32'd0);
    check("rst_out_wdata", ram_wdata_o, 32'd0);
    check("rst_out_be", 32'(ram_be_o), 32'd0);
    check("rst_word_kept", mem[9], 32'hCAFE_F00D);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_release_ready", 32'(req_ready_o), 32'd1);

    // Random traffic, biased toward aligned in-range accesses.
    for (int n = 0; n < 60; n++) begin
      r_we   = 1'($urandom);
      r_uns  = 1'($urandom);
      r_size = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        r_addr = 32'($urandom_range(0, 32'h13F));
      end else begin
        r_addr = 32'($urandom_range(0, 255));
        if (r_size == 2'd1) r_addr[0] = 1'b0;
        if (r_size == 2'd2) r_addr[1:0] = 2'b00;
      end
      do_req(r_we, r_size, r_uns, r_addr, $urandom, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
